// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS CPU front end.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0]   RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [PC_W-1:0]   PC_STEP          = 32'd4;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush empties it and wins over push.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// and hands buffered {pc, inst} pairs to decode under a valid/stall handshake.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  input  logic        stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [31:0]      pc;
  logic [31:0]      inflight_pc;
  logic             inflight;
  logic             grant;
  logic             pop;
  logic             push;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic [CRD_W-1:0] credit;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             unused_redirect_lsbs;

  // Redirect targets are forced word-aligned; the low bits carry no meaning.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign inst_valid_o = !rst && !empty;
  assign pop          = inst_valid_o && !stall_i;

  // Buffered plus in-flight words may never exceed the FIFO, so every
  // response that comes back always has a slot waiting for it.
  assign credit    = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(pop);
  assign imem_req  = !rst && (credit < CRD_W'(DEPTH));
  assign imem_addr = pc;

  // A redirect kills a same-cycle grant and the response arriving now.
  assign grant     = imem_req && imem_gnt && !redirect_i;
  assign push      = inflight && !redirect_i;
  assign push_data = '{pc: inflight_pc, inst: imem_rdata};

  assign inst_o = inst_valid_o ? head.inst : NOP_INST;
  assign pc_o   = inst_valid_o ? head.pc   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= grant;
      if (grant) begin
        inflight_pc <= pc;
      end
      if (redirect_i) begin
        pc <= {redirect_pc[31:2], 2'b00};
      end else if (grant) begin
        pc <= pc + PC_STEP;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_i),
    .head     (head),
    .count    (count),
    .empty    (empty)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: grants push expected {pc, inst} entries,
// deliveries pop and compare; per-cycle directed expectations cover timing.
module tb_inst_fetch;

  localparam logic [31:0] RST_PC  = 32'hBFC0_0000;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;
  localparam int          MIN_DELIVERED = 30;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] imem_rdata;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid_o;

  int          checks    = 0;
  int          failures  = 0;
  int          delivered = 0;
  exp_t        exp_q[$];
  exp_t        e;
  logic [31:0] exp_addr  = RST_PC;

  // Per-cycle directed expectations, written by the stimulus only.
  bit          d_req_en  = 1'b0;
  bit          d_req     = 1'b0;
  bit          d_val_en  = 1'b0;
  bit          d_val     = 1'b0;
  bit          d_pc_en   = 1'b0;
  bit          d_inst_en = 1'b0;
  bit          d_end     = 1'b0;
  logic [31:0] d_pc      = '0;
  logic [31:0] d_inst    = '0;
  string       d_tag     = "";

  inst_fetch #(
    .RESET_PC(RST_PC),
    .DEPTH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rdata  (imem_rdata),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .stall_i     (stall_i),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .inst_valid_o(inst_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: data one cycle after a grant, garbage otherwise.
  always @(posedge clk) begin
    imem_rdata <= (imem_req && imem_gnt) ? (imem_addr ^ XOR_KEY) : 32'hDEAD_BEEF;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_addr = RST_PC;
      end else if (redirect_i) begin
        exp_q.delete();
        exp_addr = {redirect_pc[31:2], 2'b00};
      end else begin
        if (inst_valid_o && !stall_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected_valid: got pc %h expected no delivery", pc_o);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc_o, e.pc);
            check("sb_inst", inst_o, e.inst);
            delivered++;
          end
        end
        if (imem_req) begin
          check("imem_addr", imem_addr, exp_addr);
          if (imem_gnt) begin
            exp_q.push_back('{pc: exp_addr, inst: exp_addr ^ XOR_KEY});
            exp_addr = exp_addr + 32'd4;
          end
        end
      end
      if (d_req_en)  check({d_tag, "_req"},   32'(imem_req),     32'(d_req));
      if (d_val_en)  check({d_tag, "_valid"}, 32'(inst_valid_o), 32'(d_val));
      if (d_pc_en)   check({d_tag, "_pc"},    pc_o,              d_pc);
      if (d_inst_en) check({d_tag, "_inst"},  inst_o,            d_inst);
      if (d_end) begin
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_delivered_min", 32'(delivered >= MIN_DELIVERED), 32'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    d_req_en  = 1'b0;
    d_val_en  = 1'b0;
    d_pc_en   = 1'b0;
    d_inst_en = 1'b0;
    d_end     = 1'b0;
    d_tag     = "";
  endtask

  task automatic exp_req(input string t, input bit r);
    d_tag    = t;
    d_req_en = 1'b1;
    d_req    = r;
  endtask

  task automatic exp_valid(input string t, input bit v);
    d_tag    = t;
    d_val_en = 1'b1;
    d_val    = v;
  endtask

  task automatic exp_head(input string t, input logic [31:0] pc);
    exp_valid(t, 1'b1);
    d_pc_en   = 1'b1;
    d_pc      = pc;
    d_inst_en = 1'b1;
    d_inst    = pc ^ XOR_KEY;
  endtask

  task automatic exp_zero(input string t);
    exp_valid(t, 1'b0);
    d_pc_en   = 1'b1;
    d_pc      = 32'h0;
    d_inst_en = 1'b1;
    d_inst    = 32'h0;
  endtask

  initial begin
    rst         = 1'b1;
    imem_gnt    = 1'b1;
    stall_i     = 1'b0;
    redirect_i  = 1'b0;
    redirect_pc = 32'h0;

    cyc(); exp_req("reset", 1'b0); exp_zero("reset");
    cyc();
    // Streaming from reset: first valid two cycles after the first request.
    cyc(); rst = 1'b0; exp_req("c0", 1'b1); exp_valid("c0", 1'b0);
    cyc(); exp_req("c1", 1'b1); exp_valid("c1", 1'b0);
    cyc(); exp_head("c2", RST_PC);
    repeat (7) begin cyc(); exp_req("steady", 1'b1); end

    // Stall: head frozen, requests stop, then resume in order.
    for (int i = 0; i < 5; i++) begin
      cyc(); stall_i = 1'b1; exp_req("stall", 1'b0); exp_head("stall", RST_PC + 32'h20);
    end
    cyc(); stall_i = 1'b0; exp_req("stall_release", 1'b1); exp_head("stall_release", RST_PC + 32'h20);
    repeat (4) cyc();

    // Grant withheld for three cycles: FIFO drains, address held.
    cyc(); imem_gnt = 1'b0; exp_head("gnt0_a", RST_PC + 32'h34);
    cyc(); exp_head("gnt0_b", RST_PC + 32'h38);
    cyc(); exp_valid("gnt0_c", 1'b0); exp_req("gnt0_c", 1'b1);
    cyc(); imem_gnt = 1'b1; exp_valid("regrant_0", 1'b0);
    cyc(); exp_valid("regrant_1", 1'b0);
    cyc(); exp_head("regrant_2", RST_PC + 32'h3C);
    repeat (2) cyc();

    // Redirect with the FIFO full under stall; misaligned target.
    cyc(); stall_i = 1'b1;
    cyc(); exp_req("full", 1'b0); exp_valid("full", 1'b1);
    cyc(); redirect_i = 1'b1; redirect_pc = 32'h8000_0102;
    cyc(); redirect_i = 1'b0; stall_i = 1'b0; exp_valid("redir_r1", 1'b0); exp_req("redir_r1", 1'b1);
    cyc(); exp_valid("redir_r2", 1'b0);
    cyc(); exp_head("redir_r3", 32'h8000_0100);
    repeat (3) cyc();

    // Back-to-back redirects with a response in flight: last one wins.
    cyc(); redirect_i = 1'b1; redirect_pc = 32'h0000_1000;
    cyc(); redirect_pc = 32'h0000_2000;
    cyc(); redirect_i = 1'b0; exp_valid("dbl_r1", 1'b0);
    cyc(); exp_valid("dbl_r2", 1'b0);
    cyc(); exp_head("dbl_r3", 32'h0000_2000);
    repeat (3) cyc();

    // PC wrap past the top of the address space.
    cyc(); redirect_i = 1'b1; redirect_pc = 32'hFFFF_FFF9;
    cyc(); redirect_i = 1'b0;
    cyc();
    cyc(); exp_head("wrap_a", 32'hFFFF_FFF8);
    cyc(); exp_head("wrap_b", 32'hFFFF_FFFC);
    cyc(); exp_head("wrap_c", 32'h0000_0000);
    repeat (2) cyc();

    // One-cycle reset mid-stream with a response in flight.
    cyc(); rst = 1'b1; exp_req("mid_reset", 1'b0); exp_zero("mid_reset");
    cyc(); rst = 1'b0; exp_req("post_reset", 1'b1); exp_zero("post_reset");
    cyc(); exp_valid("post_reset_1", 1'b0);
    cyc(); exp_head("post_reset_2", RST_PC);
    repeat (4) cyc();

    // Drain and confirm every granted word was delivered.
    cyc(); imem_gnt = 1'b0;
    repeat (2) cyc();
    cyc(); d_end = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
